bn_rr_arbiter_4: RTL
====================

// Module: bn_rr_arbiter_4
// PURPOSE
//  Round-robin arbiter for 4 requesters; produces the registered one-hot select that
//  drives the sel port of the downstream 4:1 AND-OR selector (grant[i] -> sel[i]).
//  Holds each grant until the owner finishes, drops its request, or exceeds a hold limit.
//  Guarantees grant is all-zero or exactly one-hot, so the selector never ORs two sources.
// PARAMETERS
//  MAX_HOLD   8   max cycles one grant may last before forced release; 0 = no limit
// PORTS
//  clk          in   1  system clock, all state on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  req          in   4  request vector, req[i] = requester i wants the shared path
//  done         in   1  1-cycle pulse: current owner has finished its transfer
//  grant        out  4  registered one-hot grant (or 4'b0000); connects to selector sel
//  grant_valid  out  1  registered, = |grant
//  grant_id     out  2  registered binary index of granted requester (0 when idle)
//  timeout      out  1  registered 1-cycle pulse: grant released by MAX_HOLD expiry
// BEHAVIOUR
//  Reset (async, rst_n=0): grant=0, grant_valid=0, grant_id=0, timeout=0, ptr=0,
//   hold_cnt=0, state=IDLE; takes effect immediately, also mid-grant.
//  ptr (2 bit) = highest-priority index; search order ptr, ptr+1, ... mod 4.
//  IDLE: if |req, pick first set req[] at/after ptr; grant loads next edge -> GRANT.
//   Latency req -> grant = 1 cycle. If req=0, stay IDLE, outputs 0.
//  GRANT: grant/grant_id stable; hold_cnt increments each cycle (saturating width
//   $clog2(MAX_HOLD+1)). Release condition R, evaluated each cycle:
//   done=1, OR req[grant_id]=0, OR (MAX_HOLD!=0 AND hold_cnt==MAX_HOLD-1).
//  On R: ptr <= grant_id+1 (3 wraps to 0); hold_cnt <= 0; re-arbitrate in the same
//   cycle with the NEW ptr over current req (owner's bit included, lowest priority).
//   Winner found -> new grant next edge, stay GRANT, no idle bubble.
//   None -> grant=0, grant_valid=0, grant_id=0 next edge, -> IDLE.
//  timeout=1 for exactly one cycle (the cycle the new grant/zero appears) only when R
//   is caused solely by hold expiry; done or req drop in same cycle suppresses it.
//  Sole requester timing out is re-granted immediately: grant value unchanged,
//   timeout pulses, hold_cnt restarts.
//  done while IDLE: ignored. Changes to non-owner req bits during GRANT: no effect
//   until next release. Owner never starves others: after release it has lowest priority.
//  Invariant: $onehot0(grant); grant_valid == |grant; grant[grant_id]==grant_valid.
// STRUCTURE
//  Shared package bn_arb_pkg: N_REQ=4, ID_W=2, state encoding ST_IDLE=1'b0,
//   ST_GRANT=1'b1. Consumers (selector wrapper, bench) import N_REQ/ID_W from it.
//  Sub-module bn_rr_pick: combinational rotate-priority picker
//   (req[3:0], ptr[1:0]) -> (found, pick_onehot[3:0], pick_id[1:0]); used once.
//  Top: state reg, ptr reg, hold_cnt, output regs; all outputs come straight from flops.
// TESTING
//  1 Reset mid-grant: grant=4'b0100, pull rst_n low between edges -> all outputs 0
//    immediately; after release req=4'b0001 -> grant=4'b0001 one cycle later.
//  2 Rotation: req=4'b1111 held, done pulsed each grant -> grant sequence
//    0001,0010,0100,1000,0001 with no idle cycle between grants.
//  3 Wrap/priority: ptr=3 after serving id 2, req=4'b1001 -> grant=4'b1000, then 0001.
//  4 Timeout: MAX_HOLD=8, req=4'b0010 only, no done -> grant 0010 for 8 cycles, timeout
//    pulses once, grant stays 0010, hold_cnt restarts; with req=4'b0011 -> 0001 next.
//  5 Simultaneous: done=1 on the expiry cycle -> release, timeout stays 0.
//  6 Owner drop: req[grant_id] falls while others idle -> grant=0, grant_valid=0 next
//    cycle; done pulsed in IDLE -> no change. Assert onehot0 invariant throughout.

Source files
------------

// File: rtl/bn_arb_pkg.sv
// Shared constants and state encoding for the 4-way round-robin arbiter and its consumers.
package bn_arb_pkg;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

endpackage

// File: rtl/bn_rr_pick.sv
// Rotate-priority picker: returns the first set request at or after ptr, wrapping modulo N_REQ.
module bn_rr_pick
   import bn_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic             found,
   output logic [N_REQ-1:0] pick_onehot,
   output logic [ID_W-1:0]  pick_id
);

   logic [ID_W-1:0] idx;

   // Walk from the lowest priority upward so the highest-priority hit is written last.
   always_comb begin
      found       = 1'b0;
      pick_onehot = '0;
      pick_id     = '0;
      idx         = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ptr + ID_W'(i);
         if (req[idx]) begin
            found       = 1'b1;
            pick_onehot = N_REQ'(1) << idx;
            pick_id     = idx;
         end
      end
   end

endmodule

// File: rtl/bn_rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with grant hold, done/drop release and hold-limit timeout.
// Drives the sel port of a 4:1 AND-OR selector; grant is always zero or exactly one-hot.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; arbitrate over req from ptr each cycle
// ST_GRANT | one owner holds grant; re-arbitrate in place on release
module bn_rr_arbiter_4
   import bn_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic             grant_valid,
   output logic [ID_W-1:0]  grant_id,
   output logic             timeout
);

   localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

   arb_state_e       state;
   logic [ID_W-1:0]  ptr;
   logic [HC_W-1:0]  hold_cnt;

   logic             found;
   logic [N_REQ-1:0] pick_onehot;
   logic [ID_W-1:0]  pick_id;
   logic [ID_W-1:0]  next_ptr;
   logic [ID_W-1:0]  pick_ptr;
   logic             expire;
   logic             release_now;

   assign next_ptr    = grant_id + ID_W'(1);
   // On release the owner drops to lowest priority in the same cycle's search.
   assign pick_ptr    = (state == ST_GRANT) ? next_ptr : ptr;
   assign expire      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
   assign release_now = done || !req[grant_id] || expire;

   bn_rr_pick u_pick (
      .req         (req),
      .ptr         (pick_ptr),
      .found       (found),
      .pick_onehot (pick_onehot),
      .pick_id     (pick_id)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         ptr         <= '0;
         hold_cnt    <= '0;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_id    <= '0;
         timeout     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               timeout  <= 1'b0;
               hold_cnt <= '0;
               if (found) begin
                  grant       <= pick_onehot;
                  grant_valid <= 1'b1;
                  grant_id    <= pick_id;
                  state       <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (release_now) begin
                  ptr      <= next_ptr;
                  hold_cnt <= '0;
                  // Only a pure hold expiry counts as a timeout.
                  timeout  <= expire && !done && req[grant_id];
                  if (found) begin
                     grant       <= pick_onehot;
                     grant_valid <= 1'b1;
                     grant_id    <= pick_id;
                  end else begin
                     grant       <= '0;
                     grant_valid <= 1'b0;
                     grant_id    <= '0;
                     state       <= ST_IDLE;
                  end
               end else begin
                  timeout <= 1'b0;
                  if (hold_cnt != '1) hold_cnt <= hold_cnt + HC_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
